cache_fill_ctrl: RTL and testbench
==================================

Name: cache_fill_ctrl

Overview:
- Initiator in front of the K-way CLOCK line cache; the cache is the responder. Issues its read and write strobes and interprets its hit and out_val outputs.
- Accepts one client request at a time. Reads: hit served from the cache; miss fetched from backing memory, then allocated into the cache.
- Writes: write-through to memory, then write-allocate into the cache.
- Sits between the client port and the cache/memory pair.

Parameters:
- ADDR_WIDTH, 8, address width; must match the cache.
- LINE_WIDTH, 32, line/data width; must match the cache.
- FILL_TIMEOUT, 8, maximum FILL cycles before abort; must be >= K+2.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  client request valid
- req_ready  out  1  controller can accept a request
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  LINE_WIDTH  write data
- resp_valid  out  1  one-cycle response pulse
- resp_data  out  LINE_WIDTH  read data; echoes write data on writes
- resp_hit  out  1  request hit in cache at lookup
- resp_err  out  1  fill timed out
- cache_addr  out  ADDR_WIDTH  to cache in_addr
- cache_val  out  LINE_WIDTH  to cache in_val
- cache_read  out  1  to cache read
- cache_write  out  1  to cache write
- cache_hit  in  1  from cache hit
- cache_out  in  LINE_WIDTH  from cache out_val
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  LINE_WIDTH  memory write data
- mem_ack  in  1  memory completion, 1-cycle pulse
- mem_rdata  in  LINE_WIDTH  valid when mem_ack=1

Behaviour:
- Reset (synchronous, active-high): state=IDLE; req_ready=1.
  - resp_valid, resp_hit, resp_err, cache_read, cache_write, mem_req, mem_we = 0.
  - All data/address outputs = 0. Fill counter = 0.
  - Reset mid-operation abandons the transaction with no response; mem_req drops the next cycle.
- Handshake: request accepted when req_valid && req_ready. addr, wdata and write are latched at that edge. req_ready=1 only in IDLE.
- cache_read and cache_write are never high in the same cycle.
- cache_addr, cache_val, mem_addr and mem_wdata are driven from latched registers and are stable for the whole transaction.
- IDLE -> LOOKUP on accept.
- LOOKUP: cache_read=1 for exactly one cycle -> CHECK.
- CHECK: cache_hit and cache_out sampled (registered by the cache at the end of LOOKUP); hit bit stored.
  - read hit -> RESP with resp_data=cache_out.
  - read miss -> MEM_REQ with mem_we=0.
  - write, hit or miss -> MEM_REQ with mem_we=1.
- MEM_REQ: mem_req=1 until the cycle mem_ack=1. On ack: reads latch mem_rdata as the fill value; writes use the latched wdata. -> FILL.
  - A write that hit is still filled (updates the line).
- FILL: first cycle cache_write=1 unconditionally. Following cycles: cache_write = !cache_hit.
  - Exit to RESP on the first post-first cycle with cache_hit=1.
  - The cache's CLOCK sweep can take up to K+1 write cycles; the controller holds write throughout.
  - Fill counter increments each FILL cycle. At FILL_TIMEOUT: cache_write=0, resp_err=1 in RESP.
- RESP: resp_valid=1 for one cycle with resp_data, resp_hit (CHECK result) and resp_err -> IDLE.
- Latency in cycles, accept to resp_valid:
  - read hit: 3.
  - miss or write: 4 + memory wait + fill cycles.
- resp_* hold their values after the pulse until the next RESP; only resp_valid drops.
- mem_ack outside MEM_REQ is ignored. req_valid while busy is not accepted (no queueing).

Optional Feature:
- Macro CACHE_FILL_CTRL_STATS_EN.
- Defined: adds outputs hit_count[15:0] and miss_count[15:0].
  - Incremented in CHECK for reads only.
  - Saturate at 16'hFFFF; cleared by reset.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Read miss, then read hit:
  - Cold-filled cache, mem returns 32'hDEADBEEF for addr 8'h10 with ack 2 cycles after mem_req.
  - Then read 8'h10: first resp_data=DEADBEEF, resp_hit=0; second resp_hit=1, latency 3, mem_req never asserted.
- Write-through:
  - Write 8'h20 = 32'h12345678: mem_we=1, mem_wdata=12345678.
  - Subsequent read 8'h20 hits with 12345678.
- Eviction (K=2):
  - Read 8'h01, 8'h02, then miss 8'h03.
  - FILL lasts >1 cycle while CLOCK sweeps; exactly one of 01/02 still hits afterward; 03 hits.
- Backpressure:
  - req_valid held high during a miss; req_ready=0 until after resp_valid.
  - Second request accepted the cycle after RESP.
- Reset mid-fill:
  - Assert reset during MEM_REQ: next cycle mem_req=0, req_ready=1, resp_valid never pulses.
- Timeout:
  - Cache stub with hit tied 0 in FILL: resp_err=1 after FILL_TIMEOUT=8 FILL cycles, resp_valid single pulse.

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - single-request fill controller in front of a CLOCK line cache; CACHE_FILL_CTRL_STATS_EN adds read hit/miss counters
module cache_fill_ctrl #(
    parameter int ADDR_WIDTH   = 8,
    parameter int LINE_WIDTH   = 32,
    parameter int FILL_TIMEOUT = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [LINE_WIDTH-1:0] resp_data,
    output logic                  resp_hit,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [LINE_WIDTH-1:0] cache_val,
    output logic                  cache_read,
    output logic                  cache_write,
    input  logic                  cache_hit,
    input  logic [LINE_WIDTH-1:0] cache_out,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [LINE_WIDTH-1:0] mem_rdata
`ifdef CACHE_FILL_CTRL_STATS_EN
    ,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
`endif
);

    localparam int CW = $clog2(FILL_TIMEOUT + 1);
    localparam logic [CW-1:0] FILL_LAST = CW'(FILL_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, MEM_REQ, FILL, RESP} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic                  write_q, write_d;
    logic                  hit_q, hit_d;
    logic                  err_q, err_d;
    logic [CW-1:0]         fill_cnt_q, fill_cnt_d;
    logic                  resp_valid_q;
    logic [LINE_WIDTH-1:0] resp_data_q;
    logic                  resp_hit_q;
    logic                  resp_err_q;

    // line_q is the single data holder: write data, then the fill value, then the response data
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        line_d      = line_q;
        write_d     = write_q;
        hit_d       = hit_q;
        err_d       = err_q;
        fill_cnt_d  = fill_cnt_q;
        req_ready   = 1'b0;
        cache_read  = 1'b0;
        cache_write = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d    = LOOKUP;
                    addr_d     = req_addr;
                    line_d     = req_wdata;
                    write_d    = req_write;
                    hit_d      = 1'b0;
                    err_d      = 1'b0;
                    fill_cnt_d = '0;
                end
            end
            LOOKUP: begin
                cache_read = 1'b1;
                state_d    = CHECK;
            end
            CHECK: begin
                hit_d = cache_hit;
                if (!write_q && cache_hit) begin
                    line_d  = cache_out;
                    state_d = RESP;
                end else begin
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                mem_req = 1'b1;
                mem_we  = write_q;
                if (mem_ack) begin
                    if (!write_q) begin
                        line_d = mem_rdata;
                    end
                    state_d = FILL;
                end
            end
            FILL: begin
                fill_cnt_d = fill_cnt_q + CW'(1);
                // the hit seen in the first cycle is stale, so that cycle always writes
                if (fill_cnt_q == '0) begin
                    cache_write = 1'b1;
                end else if (cache_hit) begin
                    state_d = RESP;
                end else if (fill_cnt_q == FILL_LAST) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cache_write = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            line_q       <= '0;
            write_q      <= 1'b0;
            hit_q        <= 1'b0;
            err_q        <= 1'b0;
            fill_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_hit_q   <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            line_q       <= line_d;
            write_q      <= write_d;
            hit_q        <= hit_d;
            err_q        <= err_d;
            fill_cnt_q   <= fill_cnt_d;
            resp_valid_q <= (state_d == RESP);
            if (state_d == RESP) begin
                resp_data_q <= line_d;
                resp_hit_q  <= hit_d;
                resp_err_q  <= err_d;
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_hit   = resp_hit_q;
    assign resp_err   = resp_err_q;
    assign cache_addr = addr_q;
    assign cache_val  = line_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = line_q;

`ifdef CACHE_FILL_CTRL_STATS_EN
    logic [15:0] hit_count_q;
    logic [15:0] miss_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (state_q == CHECK && !write_q) begin
            if (cache_hit) begin
                if (hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
            end else begin
                if (miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb/tb_cache_fill_ctrl.sv - scoreboard bench with a 2-way CLOCK cache stub and a fixed-latency memory model
module tb_cache_fill_ctrl;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_hit;
    logic        resp_err;
    logic [7:0]  cache_addr;
    logic [31:0] cache_val;
    logic        cache_read;
    logic        cache_write;
    logic        cache_hit;
    logic [31:0] cache_out;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef CACHE_FILL_CTRL_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    cache_fill_ctrl #(.ADDR_WIDTH(8), .LINE_WIDTH(32), .FILL_TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit), .resp_err(resp_err),
        .cache_addr(cache_addr), .cache_val(cache_val), .cache_read(cache_read),
        .cache_write(cache_write), .cache_hit(cache_hit), .cache_out(cache_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_FILL_CTRL_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // 2-way CLOCK cache stub; a replacing or updating write reports hit
    logic        stub_hit;
    logic        force_miss = 1'b0;
    logic [7:0]  c_tag [2];
    logic [31:0] c_dat [2];
    logic        c_vld [2];
    logic        c_ref [2];
    int          c_hand;

    assign cache_hit = stub_hit && !force_miss;

    always @(posedge clock) begin : cache_model
        int idx;
        idx = -1;
        for (int i = 0; i < 2; i++)
            if (c_vld[i] && c_tag[i] == cache_addr) idx = i;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                c_vld[i] <= 1'b0;
                c_ref[i] <= 1'b0;
                c_tag[i] <= '0;
                c_dat[i] <= '0;
            end
            c_hand    <= 0;
            stub_hit  <= 1'b0;
            cache_out <= '0;
        end else if (cache_read) begin
            stub_hit  <= (idx >= 0);
            cache_out <= (idx >= 0) ? c_dat[idx] : 32'h0;
            if (idx >= 0) c_ref[idx] <= 1'b1;
        end else if (cache_write) begin
            if (idx >= 0) begin
                c_dat[idx] <= cache_val;
                c_ref[idx] <= 1'b1;
                stub_hit   <= 1'b1;
            end else if (!c_vld[c_hand] || !c_ref[c_hand]) begin
                c_tag[c_hand] <= cache_addr;
                c_dat[c_hand] <= cache_val;
                c_vld[c_hand] <= 1'b1;
                c_ref[c_hand] <= 1'b1;
                c_hand        <= 1 - c_hand;
                stub_hit      <= 1'b1;
            end else begin
                c_ref[c_hand] <= 1'b0;
                c_hand        <= 1 - c_hand;
                stub_hit      <= 1'b0;
            end
        end
    end

    // memory: ack arrives two cycles after mem_req first rises
    logic [31:0] mem [256];
    int          m_cnt;

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
            mem[8'h10] <= 32'hDEADBEEF;
            mem_ack    <= 1'b0;
            mem_rdata  <= '0;
            m_cnt      <= 0;
        end else if (mem_req && !mem_ack) begin
            if (m_cnt == 1) begin
                mem_ack <= 1'b1;
                m_cnt   <= 0;
                if (mem_we) mem[mem_addr] <= mem_wdata;
                else        mem_rdata     <= mem[mem_addr];
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else begin
            mem_ack <= 1'b0;
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        hit;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   last_acc;
    logic prev_rv = 1'b0;
    int   rv_cnt = 0, cw_cnt = 0, mreq_cnt = 0, both_cnt = 0;
    logic        cap_we;
    logic [7:0]  cap_addr;
    logic [31:0] cap_wdata;

    always @(negedge clock) begin
        if (cache_read && cache_write) both_cnt++;
        if (cache_write) cw_cnt++;
        if (mem_req) begin
            mreq_cnt++;
            cap_we    = mem_we;
            cap_addr  = mem_addr;
            cap_wdata = mem_wdata;
        end
        if (resp_valid) begin
            rv_cnt++;
            chk("resp_single_pulse", {31'b0, prev_rv}, 32'd0);
            if (q.size() == 0) begin
                chk("resp_expected", 32'(q.size()), 32'd1);
            end else begin
                mon_e = q.pop_front();
                chk("resp_data", resp_data, mon_e.data);
                chk("resp_hit", {31'b0, resp_hit}, {31'b0, mon_e.hit});
                chk("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
                chk("resp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
        prev_rv = resp_valid;
    end

    task automatic send(input logic w, input logic [7:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clock);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("accept_ready", {31'b0, req_ready}, 32'd1);
        last_acc = cyc;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic expect_resp(input logic [31:0] d, input logic h, input logic e, input int lat);
        exp_t x;
        x.data = d; x.hit = h; x.err = e; x.lat = lat; x.acc = last_acc;
        q.push_back(x);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("resp_arrived", 32'(q.size()), 32'd0);
        q.delete();
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        q.delete();
    endtask

    int snap, viol, n;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clock);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_hit_err", {30'b0, resp_hit, resp_err}, 32'd0);
        chk("rst_cache_strobes", {30'b0, cache_read, cache_write}, 32'd0);
        chk("rst_mem_req_we", {30'b0, mem_req, mem_we}, 32'd0);
        chk("rst_addr", {16'b0, cache_addr, mem_addr}, 32'd0);
        chk("rst_data", cache_val | mem_wdata, 32'd0);
        reset = 1'b0;

        // read miss then read hit
        send(1'b0, 8'h10, 32'h0); expect_resp(32'hDEADBEEF, 1'b0, 1'b0, 8); wait_idle();
        snap = mreq_cnt;
        send(1'b0, 8'h10, 32'h0); expect_resp(32'hDEADBEEF, 1'b1, 1'b0, 3); wait_idle();
        chk("hit_no_mem_req", 32'(mreq_cnt - snap), 32'd0);

        // write-through: miss, then hit
        send(1'b1, 8'h20, 32'h12345678); expect_resp(32'h12345678, 1'b0, 1'b0, 8); wait_idle();
        chk("wr_mem_we", {31'b0, cap_we}, 32'd1);
        chk("wr_mem_wdata", cap_wdata, 32'h12345678);
        chk("wr_mem_addr", {24'b0, cap_addr}, 32'h20);
        send(1'b0, 8'h20, 32'h0); expect_resp(32'h12345678, 1'b1, 1'b0, 3); wait_idle();
        send(1'b1, 8'h20, 32'hCAFEF00D); expect_resp(32'hCAFEF00D, 1'b1, 1'b0, 8); wait_idle();
        chk("wr_hit_mem_content", mem[8'h20], 32'hCAFEF00D);
        send(1'b0, 8'h20, 32'h0); expect_resp(32'hCAFEF00D, 1'b1, 1'b0, 3); wait_idle();

        // eviction with two ways
        do_reset();
        send(1'b0, 8'h01, 32'h0); expect_resp(32'hC0DE0001, 1'b0, 1'b0, 8); wait_idle();
        send(1'b0, 8'h02, 32'h0); expect_resp(32'hC0DE0002, 1'b0, 1'b0, 8); wait_idle();
        snap = cw_cnt;
        send(1'b0, 8'h03, 32'h0); expect_resp(32'hC0DE0003, 1'b0, 1'b0, 10); wait_idle();
        chk("evict_fill_writes", 32'(cw_cnt - snap), 32'd3);
        send(1'b0, 8'h02, 32'h0); expect_resp(32'hC0DE0002, 1'b1, 1'b0, 3); wait_idle();
        send(1'b0, 8'h03, 32'h0); expect_resp(32'hC0DE0003, 1'b1, 1'b0, 3); wait_idle();
        send(1'b0, 8'h01, 32'h0); expect_resp(32'hC0DE0001, 1'b0, 1'b0, 10); wait_idle();

        // backpressure: req_valid held through a miss
        do_reset();
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h05; req_wdata = '0;
        chk("bp_ready_idle", {31'b0, req_ready}, 32'd1);
        last_acc = cyc;
        expect_resp(32'hC0DE0005, 1'b0, 1'b0, 8);
        @(negedge clock);
        viol = 0; n = 0;
        while (!resp_valid && n < 50) begin
            if (req_ready) viol++;
            @(negedge clock);
            n++;
        end
        chk("bp_resp_seen", {31'b0, resp_valid}, 32'd1);
        chk("bp_busy_ready_low", 32'(viol), 32'd0);
        chk("bp_ready_in_resp", {31'b0, req_ready}, 32'd0);
        @(negedge clock);
        chk("bp_ready_after_resp", {31'b0, req_ready}, 32'd1);
        last_acc = cyc;
        expect_resp(32'hC0DE0005, 1'b1, 1'b0, 3);
        @(negedge clock);
        req_valid = 1'b0;
        wait_idle();

        // reset while in MEM_REQ
        do_reset();
        send(1'b0, 8'h06, 32'h0);
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("midrst_mem_req_seen", {31'b0, mem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_mem_req_drop", {31'b0, mem_req}, 32'd0);
        chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        reset = 1'b0;
        snap = rv_cnt;
        repeat (20) @(negedge clock);
        chk("midrst_no_resp", 32'(rv_cnt - snap), 32'd0);

        // fill timeout with the cache never reporting hit
        do_reset();
        force_miss = 1'b1;
        snap = cw_cnt;
        send(1'b0, 8'h07, 32'h0); expect_resp(32'hC0DE0007, 1'b0, 1'b1, 14); wait_idle();
        chk("tmo_fill_writes", 32'(cw_cnt - snap), 32'd7);
        repeat (2) @(negedge clock);
        chk("tmo_err_held", {31'b0, resp_err}, 32'd1);
        chk("tmo_valid_low", {31'b0, resp_valid}, 32'd0);
        force_miss = 1'b0;

        chk("no_rd_wr_overlap", 32'(both_cnt), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
